// File: rtl/tx_sender_pkg.sv
// Shared types and framing constants for the TX cache UART sender.
package tx_sender_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    FETCH,
    WAITQ,
    SEND,
    TAIL
  } tx_state_t;

  // Frame header and trailer bytes
  localparam logic [7:0] HDR0 = 8'h01;
  localparam logic [7:0] HDR1 = 8'hFE;
  localparam logic [7:0] TRL0 = 8'hFE;
  localparam logic [7:0] TRL1 = 8'h01;

  // Selects the fixed framing byte for the header (is_tail = 0) or trailer (is_tail = 1)
  function automatic logic [7:0] frame_const(input logic is_tail, input logic idx);
    if (!is_tail) return idx ? HDR1 : HDR0;
    else          return idx ? TRL1 : TRL0;
  endfunction

endpackage

// File: rtl/tx_cache_uart_sender_uart.sv
// 8N1 UART byte transmitter: start bit, D0..D7 LSB first, stop bit,
// each bit held for CLKS_PER_BIT clocks. done pulses during the last
// clock of the stop bit so a new byte can be started on the next cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  logic        r_txd;
  logic        r_busy;
  logic [15:0] r_clk_cnt;
  logic [3:0]  r_bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]  r_shift;
  logic        w_bit_end;

  assign w_bit_end = r_busy && (r_clk_cnt == LAST_CLK);
  assign done      = w_bit_end && (r_bit_idx == 4'd9);
  assign txd       = r_txd;
  assign busy      = r_busy;

  // Bit timer and shift register; the line is registered so it never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (!r_busy) begin
      if (start) begin
        r_busy    <= 1'b1;
        r_txd     <= 1'b0;
        r_shift   <= data;
        r_bit_idx <= '0;
        r_clk_cnt <= '0;
      end
    end else if (!w_bit_end) begin
      r_clk_cnt <= r_clk_cnt + 16'd1;
    end else begin
      r_clk_cnt <= '0;
      if (r_bit_idx == 4'd9) begin
        r_busy <= 1'b0;
        r_txd  <= 1'b1;
      end else begin
        r_bit_idx <= r_bit_idx + 4'd1;
        if (r_bit_idx == 4'd8) begin
          r_txd <= 1'b1;
        end else begin
          r_txd   <= r_shift[0];
          r_shift <= {1'b0, r_shift[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/tx_cache_uart_sender.sv
// Drains the TX cache FIFO filled by the frame reader and streams each
// frame over UART as 01 FE <payload> FE 01. A frame is armed by the
// falling edge of RD_FRAME (reader starting a frame).
module tx_cache_uart_sender
  import tx_sender_pkg::*;
#(
  parameter int FRAME_BYTES  = 145600,
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       CLK_40M,
  input  logic       RST_N,
  input  logic       RD_FRAME,
  input  logic       TX_CACHE_RDEMPTY,
  input  logic [7:0] TX_CACHE_Q,
  output logic       TX_CACHE_RDCLK,
  output logic       TX_CACHE_RDREQ,
  output logic       UART_TXD,
  output logic       TX_BUSY,
  output logic       FRAME_SENT,
  output logic       OVERRUN
);

  localparam logic [31:0] FRAME_BYTES_32 = 32'(FRAME_BYTES);

  tx_state_t   r_state;
  logic        r_rd_q1;
  logic        r_rd_q2;
  logic        r_hdr_idx;
  logic        r_issued;     // current HEAD/TAIL byte already handed to the UART
  logic        r_wait_ph;    // WAITQ: 0 = RDREQ cycle, 1 = Q valid
  logic [31:0] r_byte_cnt;
  logic        r_rdreq;
  logic        r_busy;
  logic        r_frame_sent;
  logic        r_overrun;

  logic        w_arm;
  logic        w_start;
  logic [7:0]  w_data;
  logic        w_uart_busy;
  logic        w_done;

  // Synchroniser registers reset low so a reader already mid-frame at
  // reset release does not produce a spurious arm.
  assign w_arm = r_rd_q2 & ~r_rd_q1;

  assign TX_CACHE_RDCLK = CLK_40M;
  assign TX_CACHE_RDREQ = r_rdreq;
  assign TX_BUSY        = r_busy;
  assign FRAME_SENT     = r_frame_sent;
  assign OVERRUN        = r_overrun;

  // Byte launch: framing constants in HEAD/TAIL, FIFO data straight from Q
  // in the second WAITQ cycle (the UART latches it, giving RDREQ -> start = 2 cycles)
  always_comb begin
    w_start = 1'b0;
    w_data  = 8'h00;
    case (r_state)
      HEAD: begin
        w_start = !r_issued && !w_uart_busy;
        w_data  = frame_const(1'b0, r_hdr_idx);
      end
      TAIL: begin
        w_start = !r_issued && !w_uart_busy;
        w_data  = frame_const(1'b1, r_hdr_idx);
      end
      WAITQ: begin
        w_start = r_wait_ph;
        w_data  = TX_CACHE_Q;
      end
      default: ;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (CLK_40M),
    .rst_n (RST_N),
    .start (w_start),
    .data  (w_data),
    .txd   (UART_TXD),
    .busy  (w_uart_busy),
    .done  (w_done)
  );

  // Frame sequencer with synchroniser, byte counter and status flags
  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_rd_q1      <= 1'b0;
      r_rd_q2      <= 1'b0;
      r_hdr_idx    <= 1'b0;
      r_issued     <= 1'b0;
      r_wait_ph    <= 1'b0;
      r_byte_cnt   <= '0;
      r_rdreq      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_sent <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rd_q1      <= RD_FRAME;
      r_rd_q2      <= r_rd_q1;
      r_rdreq      <= 1'b0;
      r_frame_sent <= 1'b0;
      if (w_arm && (r_state != IDLE)) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_arm) begin
            r_state    <= HEAD;
            r_busy     <= 1'b1;
            r_byte_cnt <= '0;
            r_hdr_idx  <= 1'b0;
            r_issued   <= 1'b0;
          end
        end
        HEAD: begin
          if (w_start) begin
            r_issued <= 1'b1;
          end else if (r_issued && w_done) begin
            r_issued <= 1'b0;
            if (r_hdr_idx) r_state   <= FETCH;
            else           r_hdr_idx <= 1'b1;
          end
        end
        FETCH: begin
          if (r_byte_cnt == FRAME_BYTES_32) begin
            r_state   <= TAIL;
            r_hdr_idx <= 1'b0;
            r_issued  <= 1'b0;
          end else if (!TX_CACHE_RDEMPTY) begin
            r_rdreq   <= 1'b1;
            r_wait_ph <= 1'b0;
            r_state   <= WAITQ;
          end
        end
        WAITQ: begin
          if (!r_wait_ph) r_wait_ph <= 1'b1;
          else            r_state   <= SEND;
        end
        SEND: begin
          if (w_done) begin
            r_byte_cnt <= r_byte_cnt + 32'd1;
            r_state    <= FETCH;
          end
        end
        TAIL: begin
          if (w_start) begin
            r_issued <= 1'b1;
          end else if (r_issued && w_done) begin
            r_issued <= 1'b0;
            if (r_hdr_idx) begin
              r_frame_sent <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_hdr_idx <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_cache_uart_sender.sv
// Testbench for tx_cache_uart_sender: FIFO model, UART line decoder and
// expected-byte scoreboard, with one task per scenario.
module tb_tx_cache_uart_sender;

  localparam int FB  = 4;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_frame = 1'b1;
  logic       rdempty = 1'b1;
  logic [7:0] q = 8'h00;
  logic       rdclk, rdreq, txd, tx_busy, frame_sent, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int rdreq_cnt   = 0;
  int fs_cnt      = 0;
  int byte_starts = 0;
  int rst_events  = 0;

  tx_cache_uart_sender #(
    .FRAME_BYTES (FB),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK_40M         (clk),
    .RST_N           (rst_n),
    .RD_FRAME        (rd_frame),
    .TX_CACHE_RDEMPTY(rdempty),
    .TX_CACHE_Q      (q),
    .TX_CACHE_RDCLK  (rdclk),
    .TX_CACHE_RDREQ  (rdreq),
    .UART_TXD        (txd),
    .TX_BUSY         (tx_busy),
    .FRAME_SENT      (frame_sent),
    .OVERRUN         (overrun)
  );

  always #5 clk = ~clk;

  // Normal-mode FIFO: data appears on Q the cycle after RDREQ
  always @(posedge clk) begin
    if (rdreq && fifo_q.size() > 0) q <= fifo_q.pop_front();
    rdempty <= (fifo_q.size() == 0);
  end

  // RDREQ and FRAME_SENT monitor; every RDREQ must see a non-empty FIFO
  always @(negedge clk) begin
    if (frame_sent) fs_cnt++;
    if (rdreq) begin
      rdreq_cnt++;
      n_checks++;
      if (rdempty) begin
        n_fail++;
        $display("FAIL rdreq_while_empty: rdreq=1 rdempty=%b, required rdempty=0", rdempty);
      end
    end
  end

  always @(negedge rst_n) rst_events++;

  // UART decoder: samples all 40 cycles of a byte, checks bit widths and scoreboard
  logic [39:0] dec_s;
  logic [7:0]  dec_b;
  logic [7:0]  dec_e;
  int          dec_r0;
  bit          dec_ok;
  always @(negedge clk) begin
    if (rst_n && txd == 1'b0) begin
      dec_r0 = rst_events;
      byte_starts++;
      dec_s[0] = txd;
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        dec_s[i] = txd;
      end
      if (dec_r0 == rst_events) begin
        dec_ok = (dec_s[3:0] == 4'b0000) && (dec_s[39:36] == 4'b1111);
        for (int k = 1; k < 9; k++) begin
          dec_b[k-1] = dec_s[4*k+2];
          for (int j = 0; j < 4; j++)
            if (dec_s[4*k+j] !== dec_s[4*k+2]) dec_ok = 0;
        end
        n_checks++;
        if (!dec_ok) begin
          n_fail++;
          $display("FAIL bit_width: samples=%h, required 4-cycle bits with start 0 and stop 1", dec_s);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got %h, required no byte", dec_b);
        end else begin
          dec_e = exp_q.pop_front();
          if (dec_b !== dec_e) begin
            n_fail++;
            $display("FAIL uart_byte: got %h, required %h", dec_b, dec_e);
          end
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic fifo_push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  // Push the full expected frame, then pulse RD_FRAME low
  task automatic arm(input logic [7:0] p0, input logic [7:0] p1,
                     input logic [7:0] p2, input logic [7:0] p3);
    exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
    exp_q.push_back(p0); exp_q.push_back(p1); exp_q.push_back(p2); exp_q.push_back(p3);
    exp_q.push_back(8'hFE); exp_q.push_back(8'h01);
    @(negedge clk);
    rd_frame = 1'b0;
    repeat (4) @(negedge clk);
    rd_frame = 1'b1;
  endtask

  task automatic wait_frame(output bit ok, output bit busy_dropped);
    ok = 0;
    busy_dropped = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_sent) begin
        ok = 1;
        break;
      end
      if (!tx_busy) busy_dropped = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (txd !== 1'b1)       begin n_fail++; $display("FAIL reset_txd: got %b, required 1", txd); end
    n_checks++; if (rdreq !== 1'b0)     begin n_fail++; $display("FAIL reset_rdreq: got %b, required 0", rdreq); end
    n_checks++; if (tx_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
    n_checks++; if (frame_sent !== 1'b0) begin n_fail++; $display("FAIL reset_frame_sent: got %b, required 0", frame_sent); end
    n_checks++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int r0, f0;
    bit ok, dropped;
    r0 = rdreq_cnt; f0 = fs_cnt;
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33); fifo_push(8'h44);
    repeat (2) @(negedge clk);
    arm(8'h11, 8'h22, 8'h33, 8'h44);
    wait_frame(ok, dropped);
    n_checks++; if (!ok)      begin n_fail++; $display("FAIL basic_frame_sent: got timeout, required FRAME_SENT pulse"); end
    n_checks++; if (dropped)  begin n_fail++; $display("FAIL basic_busy: got TX_BUSY=0 mid-frame, required 1"); end
    repeat (20) @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b, required 0", tx_busy); end
    n_checks++; if (rdreq_cnt - r0 != 4) begin n_fail++; $display("FAIL basic_rdreq_count: got %0d, required 4", rdreq_cnt - r0); end
    n_checks++; if (fs_cnt - f0 != 1) begin n_fail++; $display("FAIL basic_frame_sent_count: got %0d, required 1", fs_cnt - f0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_bytes_left: got %0d undelivered, required 0", exp_q.size()); end
    $display("test_basic done");
  endtask

  task automatic test_bit_timing();
    bit ok, dropped;
    fifo_push(8'hA5); fifo_push(8'h5A); fifo_push(8'h00); fifo_push(8'hFF);
    repeat (2) @(negedge clk);
    arm(8'hA5, 8'h5A, 8'h00, 8'hFF);
    wait_frame(ok, dropped);
    repeat (20) @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL timing_frame_sent: got timeout, required FRAME_SENT pulse"); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL timing_bytes_left: got %0d undelivered, required 0", exp_q.size()); end
    $display("test_bit_timing done");
  endtask

  task automatic test_empty_stall();
    int r0, i;
    bit ok, dropped, txd_low, req_seen;
    r0 = rdreq_cnt;
    fifo_push(8'hAA); fifo_push(8'hBB);
    repeat (2) @(negedge clk);
    arm(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    for (i = 0; i < 2000 && exp_q.size() > 4; i++) @(negedge clk);
    n_checks++; if (exp_q.size() != 4) begin n_fail++; $display("FAIL stall_reach: got %0d left, required 4", exp_q.size()); end
    txd_low = 0; req_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) txd_low = 1;
      if (rdreq) req_seen = 1;
    end
    n_checks++; if (txd_low)  begin n_fail++; $display("FAIL stall_txd: got 0 during stall, required 1"); end
    n_checks++; if (req_seen) begin n_fail++; $display("FAIL stall_rdreq: got RDREQ during stall, required none"); end
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b, required 1", tx_busy); end
    fifo_push(8'hCC); fifo_push(8'hDD);
    wait_frame(ok, dropped);
    repeat (20) @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_frame_sent: got timeout, required FRAME_SENT pulse"); end
    n_checks++; if (rdreq_cnt - r0 != 4) begin n_fail++; $display("FAIL stall_rdreq_count: got %0d, required 4", rdreq_cnt - r0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_bytes_left: got %0d undelivered, required 0", exp_q.size()); end
    $display("test_empty_stall done");
  endtask

  task automatic test_overrun();
    int r0, f0, i;
    bit ok, dropped;
    r0 = rdreq_cnt; f0 = fs_cnt;
    fifo_push(8'h01); fifo_push(8'h02); fifo_push(8'h03); fifo_push(8'h04);
    repeat (2) @(negedge clk);
    arm(8'h01, 8'h02, 8'h03, 8'h04);
    for (i = 0; i < 2000 && rdreq_cnt == r0; i++) @(negedge clk);
    rd_frame = 1'b0;
    repeat (4) @(negedge clk);
    rd_frame = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, required 1", overrun); end
    wait_frame(ok, dropped);
    repeat (150) @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL overrun_frame_sent: got timeout, required FRAME_SENT pulse"); end
    n_checks++; if (fs_cnt - f0 != 1) begin n_fail++; $display("FAIL overrun_frames: got %0d, required 1", fs_cnt - f0); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL overrun_bytes_left: got %0d undelivered, required 0", exp_q.size()); end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid();
    int b0, i;
    bit ok, dropped;
    b0 = byte_starts;
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33); fifo_push(8'h44);
    repeat (2) @(negedge clk);
    arm(8'h11, 8'h22, 8'h33, 8'h44);
    for (i = 0; i < 2000 && byte_starts < b0 + 4; i++) @(negedge clk);
    n_checks++; if (byte_starts != b0 + 4) begin n_fail++; $display("FAIL rstmid_reach: got %0d starts, required %0d", byte_starts - b0, 4); end
    repeat (13) @(negedge clk);
    n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3: got txd=%b in bit D2 of 0x22, required 0", txd); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (txd !== 1'b1)     begin n_fail++; $display("FAIL rstmid_txd: got %b, required 1", txd); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", tx_busy); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun_cleared: got %b, required 0", overrun); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_busy: got %b, required 0", tx_busy); end
    fifo_push(8'h55); fifo_push(8'h66);
    repeat (2) @(negedge clk);
    arm(8'h33, 8'h44, 8'h55, 8'h66);
    wait_frame(ok, dropped);
    repeat (20) @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_frame_sent: got timeout, required FRAME_SENT pulse"); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_bytes_left: got %0d undelivered, required 0", exp_q.size()); end
    $display("test_reset_mid done");
  endtask

  task automatic test_idle();
    bit txd_low, req_seen;
    txd_low = 0; req_seen = 0;
    fifo_push(8'h77);
    rd_frame = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) txd_low = 1;
      if (rdreq) req_seen = 1;
    end
    n_checks++; if (txd_low)  begin n_fail++; $display("FAIL idle_txd: got 0, required constant 1"); end
    n_checks++; if (req_seen) begin n_fail++; $display("FAIL idle_rdreq: got RDREQ, required none"); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL idle_overrun: got %b, required 0", overrun); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", tx_busy); end
    $display("test_idle done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bit_timing();
    test_empty_stall();
    test_overrun();
    test_reset_mid();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
